fde_sequencer: RTL and testbench
================================

# fde_sequencer

Parametrised fetch-decode-execute sequencer for the processor core. It holds the program counter and the instruction register. It fetches instructions from program ROM over a req/ack handshake, splits each one into opcode and two arguments, and issues them to the instruction decoder/executor over a valid/done handshake. It then updates the PC for sequential, jump, conditional-branch and halt flow, and counts retired instructions.

## Interface
- PC_WIDTH, 16, program counter and ROM address width
- OPC_WIDTH, 8, opcode field width
- ARG_WIDTH, 16, width of each argument field; instruction word is OPC_WIDTH+2*ARG_WIDTH (40 by default), laid out {opcode, arg1, arg2} MSB first
- RESET_PC, 0, PC value loaded at reset
- OPC_JUMP, 8'h09, unconditional jump; target taken from exec_result
- OPC_BRZ, 8'h0A, branch to arg1 if exec_zero, else fall through
- OPC_HALT, 8'hFF, stop fetching until reset
- CNT_WIDTH, 16, retired-instruction counter width

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- rom_addr  out  PC_WIDTH  fetch address, always equal to pc
- rom_req  out  1  fetch request
- rom_ack  in  1  ROM data valid
- rom_data  in  OPC_WIDTH+2*ARG_WIDTH  instruction word
- exec_valid  out  1  instruction presented to executor
- exec_opcode  out  OPC_WIDTH  IR opcode field
- exec_arg1  out  ARG_WIDTH  IR arg1 field
- exec_arg2  out  ARG_WIDTH  IR arg2 field
- exec_done  in  1  executor finished current instruction
- exec_result  in  ARG_WIDTH  executor result (jump target)
- exec_zero  in  1  executor zero flag (BRZ condition)
- pc  out  PC_WIDTH  current program counter
- halted  out  1  sequencer stopped on OPC_HALT
- instr_count  out  CNT_WIDTH  retired instructions

## Operation
- States: IDLE, FETCH, EXEC, HALTED. All outputs are Moore outputs, derived from the state and registers only.
- Reset (reset_n low, asynchronous) sets:
  - state=IDLE, pc=RESET_PC, IR=0, instr_count=0
  - rom_req=0, exec_valid=0, halted=0
- IDLE: go to FETCH on the next edge.
- FETCH:
  - rom_req=1, rom_addr=pc.
  - On an edge with rom_ack=1, load IR from rom_data.
  - If rom_data opcode==OPC_HALT, go to HALTED. The PC is not advanced and the instruction is neither issued nor counted.
  - Otherwise go to EXEC.
- EXEC:
  - exec_valid=1; the exec_* fields are driven from IR and held stable.
  - On an edge with exec_done=1: update the PC, increment instr_count, go to FETCH.
- PC update:
  - OPC_JUMP: pc=exec_result.
  - OPC_BRZ: pc=arg1 if exec_zero=1, else pc+1.
  - Any other opcode: pc+1.
- Width rules:
  - pc+1 wraps modulo 2^PC_WIDTH (max to 0).
  - Targets wider than PC_WIDTH are truncated to the low bits; narrower targets are zero-extended.
  - instr_count wraps at 2^CNT_WIDTH.
- HALTED: halted=1, rom_req=0, exec_valid=0. Only reset leaves this state.
- Ignored inputs:
  - rom_ack outside FETCH.
  - exec_done outside EXEC.
  - rom_data/exec_result/exec_zero when their qualifier is low.

## Timing
- First rom_req appears one cycle after reset_n rises (IDLE lasts one cycle).
- Fetch latency:
  - IR is loaded on the same edge that samples rom_ack=1.
  - exec_valid rises in the following cycle.
  - rom_ack may be held low any number of cycles; rom_req stays high and rom_addr stays stable meanwhile.
- Execute latency:
  - pc, instr_count and the state change on the edge sampling exec_done=1.
  - rom_req with the new rom_addr is high in the next cycle.
- Minimum instruction period is 2 cycles (ack in first FETCH cycle, done in first EXEC cycle).
- exec_done high on the very first EXEC cycle is legal and retires the instruction.
- Reset asserted mid-fetch or mid-execute:
  - All outputs return to reset values immediately (asynchronously).
  - The in-flight instruction is discarded and is not counted.

## Test plan
- Reset release, ROM acks each fetch in 1 cycle, executor done in 1 cycle, program of NOPs (opcode 00) -> rom_addr sequence 0,1,2,3 with rom_req high every other cycle; instr_count=4 after 8 cycles in FETCH/EXEC.
- ROM ack delayed 3 cycles at addr 5 -> rom_req held, rom_addr=5 stable for 4 cycles; exec_valid stays 0 until the cycle after ack.
- At pc=2, instruction {09,0000,0000} with exec_result=0x0040 -> next rom_addr=0x40. BRZ {0A,0010,0000}: exec_zero=1 gives next addr 0x10; exec_zero=0 gives 3.
- pc=0xFFFF with NOP -> next rom_addr=0x0000; instr_count at 0xFFFF wraps to 0.
- Fetch of {FF,...} at pc=7 -> halted=1 the next cycle; pc=7; rom_req and exec_valid 0 for 20 cycles; instr_count unchanged.
- reset_n pulsed low while in EXEC with exec_done=0 -> immediately exec_valid=0, pc=RESET_PC, instr_count=0; refetch from RESET_PC one cycle after release.

Source files
------------

// File: rtl/fde_sequencer.sv
// fde_sequencer: fetch-decode-execute sequencer for the core.
// Holds PC and IR, fetches over req/ack, issues over valid/done.
module fde_sequencer #(
  parameter int PC_WIDTH = 16,
  parameter int OPC_WIDTH = 8,
  parameter int ARG_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [OPC_WIDTH-1:0] OPC_JUMP = 8'h09,
  parameter logic [OPC_WIDTH-1:0] OPC_BRZ = 8'h0A,
  parameter logic [OPC_WIDTH-1:0] OPC_HALT = 8'hFF,
  parameter int CNT_WIDTH = 16
) (
  input  logic clock,
  input  logic reset_n,
  output logic [PC_WIDTH-1:0] rom_addr,
  output logic rom_req,
  input  logic rom_ack,
  input  logic [OPC_WIDTH+2*ARG_WIDTH-1:0] rom_data,
  output logic exec_valid,
  output logic [OPC_WIDTH-1:0] exec_opcode,
  output logic [ARG_WIDTH-1:0] exec_arg1,
  output logic [ARG_WIDTH-1:0] exec_arg2,
  input  logic exec_done,
  input  logic [ARG_WIDTH-1:0] exec_result,
  input  logic exec_zero,
  output logic [PC_WIDTH-1:0] pc,
  output logic halted,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam int IW = OPC_WIDTH + 2 * ARG_WIDTH;

  typedef enum logic [1:0] {
    Idle,
    Fetch,
    Exec,
    Halted
  } state_t;

  state_t state;
  logic [IW-1:0] ir;
  logic [OPC_WIDTH-1:0] romOpc;
  logic [PC_WIDTH-1:0] pcInc;
  logic [PC_WIDTH-1:0] jumpTgt;
  logic [PC_WIDTH-1:0] brzTgt;
  logic [PC_WIDTH-1:0] nextPc;
  logic isJump;
  logic takeBrz;

  assign exec_opcode = ir[IW-1 -: OPC_WIDTH];
  assign exec_arg1 = ir[2*ARG_WIDTH-1 -: ARG_WIDTH];
  assign exec_arg2 = ir[ARG_WIDTH-1:0];
  assign romOpc = rom_data[IW-1 -: OPC_WIDTH];
  assign rom_addr = pc;

  // Targets are truncated or zero-extended to the PC width.
  assign pcInc = pc + PC_WIDTH'(1);
  assign jumpTgt = PC_WIDTH'(exec_result);
  assign brzTgt = PC_WIDTH'(exec_arg1);
  assign isJump = (exec_opcode == OPC_JUMP);
  assign takeBrz = (exec_opcode == OPC_BRZ) && exec_zero;

  // Select the PC that follows the instruction held in IR.
  always_comb begin
    nextPc = pcInc;
    unique case (1'b1)
      isJump:  nextPc = jumpTgt;
      takeBrz: nextPc = brzTgt;
      default: nextPc = pcInc;
    endcase
  end

  // Sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= Idle;
      pc <= RESET_PC;
      ir <= '0;
      instr_count <= '0;
      rom_req <= 1'b0;
      exec_valid <= 1'b0;
      halted <= 1'b0;
    end else begin
      unique case (state)
        Idle: begin
          state <= Fetch;
          rom_req <= 1'b1;
        end
        Fetch: begin
          if (rom_ack) begin
            ir <= rom_data;
            rom_req <= 1'b0;
            if (romOpc == OPC_HALT) begin
              state <= Halted;
              halted <= 1'b1;
            end else begin
              state <= Exec;
              exec_valid <= 1'b1;
            end
          end
        end
        Exec: begin
          if (exec_done) begin
            pc <= nextPc;
            instr_count <= instr_count + CNT_WIDTH'(1);
            exec_valid <= 1'b0;
            rom_req <= 1'b1;
            state <= Fetch;
          end
        end
        Halted: begin
          rom_req <= 1'b0;
          exec_valid <= 1'b0;
          halted <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fde_sequencer.sv
// tb_fde_sequencer: random ROM/executor responders,
// reference model feeding a scoreboard checked by a monitor.
module tb_fde_sequencer;

  localparam int CW = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [15:0] rom_addr;
  logic rom_req;
  logic rom_ack = 1'b0;
  logic [39:0] rom_data = '0;
  logic exec_valid;
  logic [7:0] exec_opcode;
  logic [15:0] exec_arg1;
  logic [15:0] exec_arg2;
  logic exec_done = 1'b0;
  logic [15:0] exec_result = '0;
  logic exec_zero = 1'b0;
  logic [15:0] pc;
  logic halted;
  logic [CW-1:0] instr_count;

  fde_sequencer #(.CNT_WIDTH(CW)) dut (
    .clock(clock), .reset_n(reset_n),
    .rom_addr(rom_addr), .rom_req(rom_req),
    .rom_ack(rom_ack), .rom_data(rom_data),
    .exec_valid(exec_valid), .exec_opcode(exec_opcode),
    .exec_arg1(exec_arg1), .exec_arg2(exec_arg2),
    .exec_done(exec_done), .exec_result(exec_result),
    .exec_zero(exec_zero), .pc(pc), .halted(halted),
    .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    int addr;
    int cnt;
    int cyc;
  } fetch_t;

  typedef struct {
    logic [39:0] w;
    int cyc;
  } issue_t;

  logic [39:0] rom [65536];
  fetch_t fetchQ[$];
  issue_t issueQ[$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  bit driverOn = 0;
  bit allowDone = 1;
  bit fast = 0;

  int modelPc;
  int modelCnt;
  int retired;
  bit modelHalted;
  logic [39:0] curWord;

  always @(posedge clock) cyc++;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ROM and executor responders; the model predicts the outcome.
  always @(negedge clock) begin
    if (!driverOn) begin
      rom_ack = 1'b0;
      exec_done = 1'b0;
    end else begin
      rom_ack = 1'b0;
      exec_done = 1'b0;
      rom_data = {$urandom, 8'($urandom)};
      exec_result = 16'($urandom);
      exec_zero = 1'($urandom);
      if (rom_req) begin
        if (fast || $urandom_range(0, 3) == 0) begin
          rom_ack = 1'b1;
          rom_data = rom[rom_addr];
          curWord = rom[modelPc];
          if (curWord[39:32] == 8'hFF) modelHalted = 1;
          else issueQ.push_back('{curWord, cyc + 1});
        end
      end else begin
        rom_ack = 1'($urandom);
      end
      if (exec_valid) begin
        if (allowDone && (fast || $urandom_range(0, 2) == 0)) begin
          exec_done = 1'b1;
          if ($urandom_range(0, 7) == 0) exec_result = 16'hFFFF;
          if (curWord[39:32] == 8'h09)
            modelPc = int'(exec_result);
          else if (curWord[39:32] == 8'h0A && exec_zero)
            modelPc = int'(curWord[31:16]);
          else
            modelPc = (modelPc + 1) % 65536;
          modelCnt = (modelCnt + 1) % (1 << CW);
          retired++;
          fetchQ.push_back('{modelPc, modelCnt, cyc + 1});
        end
      end else begin
        exec_done = 1'($urandom);
      end
    end
  end

  bit prevReq = 0;
  bit prevVal = 0;
  fetch_t curF;
  issue_t curI;

  // Monitor: pops expectations whenever the DUT presents a fetch or issue.
  always @(negedge clock) begin
    if (!reset_n) begin
      prevReq = 0;
      prevVal = 0;
    end else begin
      if (rom_req && !prevReq) begin
        if (fetchQ.size() == 0) begin
          chk("fetch_unexpected", 64'(rom_addr), 64'hFFFF_FFFF);
        end else begin
          curF = fetchQ.pop_front();
          chk("fetch_addr", 64'(rom_addr), 64'(curF.addr));
          chk("fetch_pc", 64'(pc), 64'(curF.addr));
          chk("fetch_count", 64'(instr_count), 64'(curF.cnt));
          chk("fetch_cycle", 64'(cyc), 64'(curF.cyc));
        end
      end else if (rom_req) begin
        chk("fetch_hold", 64'(rom_addr), 64'(curF.addr));
      end
      if (exec_valid && !prevVal) begin
        if (issueQ.size() == 0) begin
          chk("issue_unexpected", 64'(exec_opcode), 64'hFFFF_FFFF);
        end else begin
          curI = issueQ.pop_front();
          chk("issue_word", {exec_opcode, exec_arg1, exec_arg2}, 64'(curI.w));
          chk("issue_cycle", 64'(cyc), 64'(curI.cyc));
        end
      end else if (exec_valid) begin
        chk("issue_hold", {exec_opcode, exec_arg1, exec_arg2}, 64'(curI.w));
      end
      prevReq = rom_req;
      prevVal = exec_valid;
    end
  end

  task automatic loadProgram(int kind);
    int r;
    logic [7:0] op;
    for (int a = 0; a < 65536; a++) begin
      rom[a] = {$urandom, 8'($urandom)};
      if (kind == 0) begin
        r = $urandom_range(0, 9);
        if (r < 2) op = 8'h09;
        else if (r < 5) op = 8'h0A;
        else op = 8'($urandom_range(0, 254));
      end else begin
        op = 8'h00;
      end
      rom[a][39:32] = op;
    end
    rom[65535][39:32] = 8'h00;
    if (kind == 2) rom[7][39:32] = 8'hFF;
  endtask

  task automatic doReset();
    driverOn = 0;
    reset_n = 1'b0;
    fetchQ.delete();
    issueQ.delete();
    modelPc = 0;
    modelCnt = 0;
    retired = 0;
    modelHalted = 0;
    repeat (2) @(negedge clock);
    fetchQ.push_back('{0, 0, cyc + 1});
    reset_n = 1'b1;
    driverOn = 1;
  endtask

  task automatic runUntil(int n, int budget);
    int i = 0;
    while (retired < n && i < budget) begin
      @(negedge clock);
      i++;
    end
    checks++;
    if (retired < n) begin
      errors++;
      $display("FAIL timeout retired=%0d required=%0d", retired, n);
    end
  endtask

  initial begin
    #1;
    chk("rst_req", 64'(rom_req), 0);
    chk("rst_valid", 64'(exec_valid), 0);
    chk("rst_halted", 64'(halted), 0);
    chk("rst_pc", 64'(pc), 0);
    chk("rst_count", 64'(instr_count), 0);

    loadProgram(1);
    fast = 1;
    doReset();
    runUntil(8, 40);

    loadProgram(0);
    fast = 0;
    doReset();
    runUntil(250, 20000);

    loadProgram(2);
    doReset();
    begin
      int i = 0;
      while (!modelHalted && i < 500) begin
        @(negedge clock);
        i++;
      end
      chk("halt_seen", 64'(modelHalted), 1);
    end
    @(negedge clock);
    repeat (20) begin
      @(negedge clock);
      chk("halt_flag", 64'(halted), 1);
      chk("halt_req", 64'(rom_req), 0);
      chk("halt_valid", 64'(exec_valid), 0);
      chk("halt_pc", 64'(pc), 7);
      chk("halt_count", 64'(instr_count), 7);
    end

    loadProgram(0);
    doReset();
    runUntil(5, 2000);
    allowDone = 0;
    begin
      int i = 0;
      while (!exec_valid && i < 100) begin
        @(negedge clock);
        i++;
      end
      chk("pre_rst_valid", 64'(exec_valid), 1);
    end
    @(negedge clock);
    #2;
    driverOn = 0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(exec_valid), 0);
    chk("mid_rst_req", 64'(rom_req), 0);
    chk("mid_rst_pc", 64'(pc), 0);
    chk("mid_rst_count", 64'(instr_count), 0);
    allowDone = 1;
    doReset();
    runUntil(3, 500);

    driverOn = 0;
    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
